// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the arbitrated two-port register bank.
package reg_bank_pkg;

    localparam int DW     = 16;
    localparam int P_CORE = 0;
    localparam int P_DBG  = 1;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Ports allowed to compete for a grant in a given arbiter state.
    function automatic logic [1:0] state_mask(arb_state_t s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; mask restricts which ports may win, pointer is the last-granted port.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RES,
    input  logic [1:0] valid,
    input  logic [1:0] mask,
    input  logic       upd,
    input  logic       upd_port,
    output logic [1:0] grant
);

    logic       last;
    logic [1:0] req;

    // Reset value 1 makes port 0 the favoured port after reset.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= upd_port;
        end
    end

    always_comb begin
        req   = valid & mask;
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-port arbitrated register bank with a lock FSM, lock idle timeout and registered read data.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int  NREG     = 8,
    parameter int  LOCK_TMO = 16,
    localparam int AW       = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic [1:0]    rq_valid,
    output logic [1:0]    rq_ready,
    input  logic [1:0]    rq_we,
    input  logic [1:0]    rq_lock,
    input  logic [AW-1:0] rq_addr0,
    input  logic [AW-1:0] rq_addr1,
    input  logic [DW-1:0] rq_wdata0,
    input  logic [DW-1:0] rq_wdata1,
    output logic [1:0]    rsp_valid,
    output logic [DW-1:0] rsp_rdata
);

    localparam int CW = $clog2(LOCK_TMO) + 1;

    arb_state_t    state, state_nxt;
    logic [CW-1:0] idle_cnt, idle_nxt;
    logic [1:0]    mask, grant, acc;
    logic          sel, own, tmo;
    logic          a_we, a_lock;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] bank [NREG];

    assign mask     = state_mask(state);
    assign rq_ready = RES ? 2'b00 : grant;
    assign acc      = rq_valid & rq_ready;
    assign sel      = acc[P_DBG];
    assign own      = (state == OWN1);
    assign a_we     = rq_we[sel];
    assign a_lock   = rq_lock[sel];
    assign a_addr   = sel ? rq_addr1 : rq_addr0;
    assign a_wdata  = sel ? rq_wdata1 : rq_wdata0;

    // On timeout the pointer is set to the owner so the waiting port is favoured next.
    rr_arb2 u_arb (
        .CLK      (CLK),
        .RES      (RES),
        .valid    (rq_valid),
        .mask     (mask),
        .upd      ((|acc) | tmo),
        .upd_port (tmo ? own : sel),
        .grant    (grant)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state    <= FREE;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = '0;
        tmo       = 1'b0;
        case (state)
            FREE: begin
                if ((|acc) && a_lock) begin
                    state_nxt = sel ? OWN1 : OWN0;
                end
            end
            OWN0, OWN1: begin
                if (idle_cnt == CW'(LOCK_TMO - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = FREE;
                end else if ((|acc) && !a_lock) begin
                    state_nxt = FREE;
                end else begin
                    idle_nxt = rq_valid[own] ? '0 : idle_cnt + CW'(1);
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int k = 0; k < NREG; k++) begin
                bank[k] <= '0;
            end
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (|acc) begin
                if (a_we) begin
                    bank[a_addr] <= a_wdata;
                end else begin
                    rsp_valid <= acc;
                    rsp_rdata <= bank[a_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed and randomized checks of reg_bank_arbiter against a behavioural model.
module tb_reg_bank_arbiter;

    localparam int NREG     = 8;
    localparam int LOCK_TMO = 16;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic [1:0]  rq_valid = '0, rq_we = '0, rq_lock = '0;
    logic [1:0]  rq_ready, rsp_valid;
    logic [2:0]  rq_addr0 = '0, rq_addr1 = '0;
    logic [15:0] rq_wdata0 = '0, rq_wdata1 = '0;
    logic [15:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner -1 means nobody holds the lock.
    logic [15:0] m_mem [NREG];
    int          m_owner, m_last, m_idle;
    logic [1:0]  m_rsp_valid;
    logic [15:0] m_rdata;
    logic [1:0]  last_rdy, last_acc;

    always #5 CLK = ~CLK;

    reg_bank_arbiter #(.NREG(NREG), .LOCK_TMO(LOCK_TMO)) dut (
        .CLK       (CLK),
        .RES       (RES),
        .rq_valid  (rq_valid),
        .rq_ready  (rq_ready),
        .rq_we     (rq_we),
        .rq_lock   (rq_lock),
        .rq_addr0  (rq_addr0),
        .rq_addr1  (rq_addr1),
        .rq_wdata0 (rq_wdata0),
        .rq_wdata1 (rq_wdata1),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_mem[k] = 16'h0000;
        m_owner     = -1;
        m_last      = 1;
        m_idle      = 0;
        m_rsp_valid = 2'b00;
        m_rdata     = 16'h0000;
    endtask

    function automatic logic [1:0] model_ready();
        if (RES) return 2'b00;
        if (m_owner == 0) return {1'b0, rq_valid[0]};
        if (m_owner == 1) return {rq_valid[1], 1'b0};
        if (rq_valid == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
        return rq_valid;
    endfunction

    task automatic set_req(input int p, input logic v, input logic we, input logic lk,
                           input logic [2:0] a, input logic [15:0] d);
        rq_valid[p] = v;
        rq_we[p]    = we;
        rq_lock[p]  = lk;
        if (p == 0) begin
            rq_addr0  = a;
            rq_wdata0 = d;
        end else begin
            rq_addr1  = a;
            rq_wdata1 = d;
        end
    endtask

    // One cycle: check ready before the edge, advance the model at the edge, check responses after.
    task automatic step();
        logic [1:0] exp_rdy, acc;
        int         p;
        logic       lk;
        logic [2:0] ad;
        #2;
        exp_rdy  = model_ready();
        last_rdy = rq_ready;
        chk("ready", {30'd0, rq_ready}, {30'd0, exp_rdy});
        acc      = rq_valid & exp_rdy;
        last_acc = acc;
        @(posedge CLK);
        p  = 0;
        lk = 1'b0;
        m_rsp_valid = 2'b00;
        if (acc != 2'b00) begin
            p  = acc[1] ? 1 : 0;
            lk = rq_lock[p];
            ad = (p == 1) ? rq_addr1 : rq_addr0;
            if (rq_we[p]) begin
                m_mem[ad % NREG] = (p == 1) ? rq_wdata1 : rq_wdata0;
            end else begin
                m_rsp_valid = acc;
                m_rdata     = m_mem[ad % NREG];
            end
            m_last = p;
        end
        if (m_owner < 0) begin
            if (acc != 2'b00 && lk) begin
                m_owner = p;
                m_idle  = 0;
            end
        end else if (m_idle == LOCK_TMO - 1) begin
            m_last  = m_owner;
            m_owner = -1;
            m_idle  = 0;
        end else if (acc != 2'b00 && !lk) begin
            m_owner = -1;
            m_idle  = 0;
        end else begin
            m_idle = rq_valid[m_owner] ? 0 : m_idle + 1;
        end
        #1;
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, m_rsp_valid});
        if (m_rsp_valid != 2'b00) chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, m_rdata});
    endtask

    task automatic do_reset();
        RES = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RES = 1'b0;
    endtask

    initial begin
        int thr;
        model_reset();
        #3;
        chk("rst_ready", {30'd0, rq_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        @(posedge CLK);
        #1;
        RES = 1'b0;

        // Fresh bank reads as zero, one response pulse per read.
        for (int a = 0; a < 8; a++) begin
            set_req(0, 1'b1, 1'b0, 1'b0, 3'(a), 16'h0);
            step();
            chk("t1_rdata", {16'd0, rsp_rdata}, 32'h0000);
            chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

        // Write from port 1, read back from port 0 on the next cycle.
        set_req(1, 1'b1, 1'b1, 1'b0, 3'd3, 16'hBEEF);
        step();
        set_req(1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0);
        step();
        chk("t2_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
        chk("t2_rsp_valid", {30'd0, rsp_valid}, 32'h1);

        // Round robin alternation from reset.
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_grant", {30'd0, last_rdy}, (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Locked read-modify-write by port 0 keeps port 1 out.
        set_req(0, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0);
        step();
        chk("t4_lock_rd", {30'd0, last_rdy}, 32'h1);
        set_req(0, 1'b1, 1'b1, 1'b0, 3'd5, 16'h1234);
        step();
        chk("t4_unlock_wr", {30'd0, last_rdy}, 32'h1);
        set_req(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        step();
        chk("t4_p1_granted", {30'd0, last_rdy}, 32'h2);

        // Lock timeout after 16 idle cycles of the owner.
        set_req(0, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0);
        step();
        chk("t5_lock", {30'd0, last_rdy}, 32'h1);
        chk("t5_rdata", {16'd0, rsp_rdata}, 32'h1234);
        set_req(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < LOCK_TMO; i++) begin
            step();
            chk("t5_locked_out", {30'd0, last_rdy}, 32'h0);
        end
        step();
        chk("t5_after_tmo", {30'd0, last_rdy}, 32'h2);

        // Reset while port 1 owns the bank with a read response pending.
        set_req(1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0);
        step();
        step();
        chk("t6_pre_rsp", {30'd0, rsp_valid}, 32'h2);
        RES = 1'b1;
        #1;
        chk("t6_rsp_drop", {30'd0, rsp_valid}, 32'h0);
        chk("t6_ready_rst", {30'd0, rq_ready}, 32'h0);
        model_reset();
        @(posedge CLK);
        #1;
        chk("t6_ready_rst2", {30'd0, rq_ready}, 32'h0);
        RES = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0);
        step();
        chk("t6_free_p0", {30'd0, last_rdy}, 32'h1);
        chk("t6_zeroed", {16'd0, rsp_rdata}, 32'h0);

        // Randomized traffic; unaccepted requests are held stable.
        for (int seg = 0; seg < 3; seg++) begin
            thr = (seg == 0) ? 6 : (seg == 1) ? 4 : 1;
            for (int c = 0; c < 300; c++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!(rq_valid[p] && !last_acc[p])) begin
                        set_req(p, ($urandom_range(0, 7) < thr), 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                                16'($urandom));
                    end
                end
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
